// File: rtl/edge_capture.sv
// Synchronises an asynchronous level input to sys_clk and emits a one-cycle
// registered pulse on the selected edge(s) of the synchronised value.
module edge_capture #(
  parameter int   SYNC_STAGES = 2,
  parameter int   EDGE_MODE   = 0,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_btn,
  output logic out
);

  // The top bit holds the previous synchronised sample, one stage past the
  // synchroniser output, so the edge compare uses two settled values.
  logic [SYNC_STAGES:0] sr;
  logic                 s_new;
  logic                 s_old;
  logic                 fall;
  logic                 rise;
  logic                 det;

  assign s_new = sr[SYNC_STAGES-1];
  assign s_old = sr[SYNC_STAGES];
  assign fall  = s_old & ~s_new;
  assign rise  = ~s_old & s_new;

  always_comb begin
    det = fall;
    case (EDGE_MODE)
      0:       det = fall;
      1:       det = rise;
      default: det = fall | rise;
    endcase
  end

  // Reset is active-high despite the _n suffix on the name.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      sr  <= {(SYNC_STAGES+1){IDLE_LEVEL}};
      out <= 1'b0;
    end else begin
      sr  <= {sr[SYNC_STAGES-1:0], i_btn};
      out <= det;
    end
  end

endmodule

// File: tb/tb_edge_capture.sv
// Bench for edge_capture: three instances covering falling/default, both-edge
// with a 3-stage synchroniser, and rising mode; expected pulses via a queue.
module tb_edge_capture;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] btn_v;
  wire  [2:0] out_v;

  int total;
  int bad;
  logic exp_q[$];

  int ss_tab[3]   = '{2, 3, 2};
  int mode_tab[3] = '{0, 2, 1};
  localparam logic IDLE = 1'b0;

  edge_capture u_dut0 (
    .sys_clk(clk), .sys_rst_n(rst_v[0]), .i_btn(btn_v[0]), .out(out_v[0])
  );

  edge_capture #(.SYNC_STAGES(3), .EDGE_MODE(2), .IDLE_LEVEL(1'b0)) u_dut1 (
    .sys_clk(clk), .sys_rst_n(rst_v[1]), .i_btn(btn_v[1]), .out(out_v[1])
  );

  edge_capture #(.SYNC_STAGES(2), .EDGE_MODE(1), .IDLE_LEVEL(1'b0)) u_dut2 (
    .sys_clk(clk), .sys_rst_n(rst_v[2]), .i_btn(btn_v[2]), .out(out_v[2])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold reset for n clock edges with random input activity, checking out=0.
  task automatic do_reset(input int which, input logic lvl, input int n, input string name);
    logic got;
    @(negedge clk);
    rst_v[which] = 1'b1;
    btn_v[which] = lvl;
    #1;
    got = out_v[which];
    total++;
    if (got !== 1'b0) begin
      bad++;
      $display("FAIL %s reset_entry dut%0d: out=%b expected 0", name, which, got);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_v[which] = (i == n - 1) ? lvl : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      got = out_v[which];
      total++;
      if (got !== 1'b0) begin
        bad++;
        $display("FAIL %s in_reset dut%0d cyc %0d: out=%b expected 0", name, which, i, got);
      end
    end
  endtask

  // Release reset and drive pat[k] in cycle k. Expected output after edge k
  // follows from the input sampled SYNC_STAGES edges earlier versus the one before.
  task automatic run_seq(input int which, input logic [63:0] pat, input int len, input string name);
    int   s;
    int   ia;
    int   ib;
    logic a;
    logic b;
    logic e;
    logic got;
    s = ss_tab[which];
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      rst_v[which] = 1'b0;
      btn_v[which] = pat[k];
      ia = k - s;
      ib = k - s - 1;
      a = (ia < 0) ? IDLE : pat[ia];
      b = (ib < 0) ? IDLE : pat[ib];
      case (mode_tab[which])
        0:       e = b & ~a;
        1:       e = ~b & a;
        default: e = a ^ b;
      endcase
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = out_v[which];
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s dut%0d cyc %0d: out=%b expected %b", name, which, k, got, e);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(0, 1'b0, 2, "reset");
    run_seq(0, 64'h0, 10, "reset_idle");
  endtask

  task automatic test_falling();
    do_reset(0, 1'b0, 2, "falling");
    run_seq(0, 64'h1F, 12, "falling");
  endtask

  task automatic test_repress_reset();
    do_reset(0, 1'b0, 2, "repress");
    run_seq(0, 64'h6, 3, "repress_pre");
    do_reset(0, 1'b0, 1, "repress_mid");
    run_seq(0, 64'h3E, 8, "repress_post");
  endtask

  task automatic test_in_flight();
    do_reset(0, 1'b0, 2, "in_flight");
    run_seq(0, 64'h0F, 5, "in_flight_pre");
    do_reset(0, 1'b0, 2, "in_flight_rst");
    run_seq(0, 64'h0, 6, "in_flight_post");
  endtask

  task automatic test_reset_mid_pulse();
    logic got;
    do_reset(0, 1'b0, 2, "mid_pulse");
    run_seq(0, 64'h0F, 7, "mid_pulse_seq");
    rst_v[0] = 1'b1;
    #1;
    got = out_v[0];
    total++;
    if (got !== 1'b0) begin
      bad++;
      $display("FAIL mid_pulse_async: out=%b expected 0 before next edge", got);
    end
    do_reset(0, 1'b0, 2, "mid_pulse_hold");
  endtask

  task automatic test_both_ss3();
    do_reset(1, 1'b0, 2, "both");
    run_seq(1, 64'h3C, 12, "both");
  endtask

  task automatic test_back_to_back();
    do_reset(1, 1'b0, 2, "b2b");
    run_seq(1, 64'hA, 10, "b2b");
    do_reset(0, 1'b0, 2, "b2b_fall");
    run_seq(0, 64'h2A, 10, "b2b_fall");
  endtask

  task automatic test_rise_release_high();
    do_reset(2, 1'b1, 2, "rise_rel");
    run_seq(2, 64'hFF, 8, "rise_rel");
  endtask

  task automatic test_random();
    logic [63:0] p;
    for (int d = 0; d < 3; d++) begin
      p = {$urandom, $urandom};
      do_reset(d, 1'b0, 2, "random");
      run_seq(d, p, 48, "random");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_v = 3'b111;
    btn_v = 3'b000;
    test_reset();
    test_falling();
    test_repress_reset();
    test_in_flight();
    test_reset_mid_pulse();
    test_both_ss3();
    test_back_to_back();
    test_rise_release_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_capture.md
# edge_capture

Synchronises an asynchronous push-button/level input `i_btn` to `sys_clk` through a shift register and emits a single-clock pulse on `out` for each selected edge. The default edge is falling. It sits between raw board inputs and control logic that needs one event per button action rather than a level.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth in flops, legal range 2..4.
- `EDGE_MODE`, default 0: selects which edge produces a pulse.
  - 0 = falling (1→0).
  - 1 = rising (0→1).
  - 2 = both.
- `IDLE_LEVEL`, default 1'b0: value loaded into every shift-register bit at reset.
- `sys_clk`  input  1  clock; all state updates on its rising edge.
- `sys_rst_n`  input  1  reset sys_rst_n, asynchronous, active-high; clock sys_clk.
  - Note: despite the `_n` suffix, reset is asserted when `sys_rst_n` = 1.
- `i_btn`  input  1  asynchronous level input, no timing relation to `sys_clk` assumed.
- `out`  output  1  registered edge pulse, high for exactly one `sys_clk` cycle per detected edge.

## Operation
- Shift register `sr` is SYNC_STAGES+1 bits wide. On each clock, `sr <= {sr[SYNC_STAGES-1:0], i_btn}`.
- Synchronised current value: `s_new = sr[SYNC_STAGES-1]`. Previous value: `s_old = sr[SYNC_STAGES]`.
- Edge detect, evaluated on each clock:
  - `fall = s_old & ~s_new`.
  - `rise = ~s_old & s_new`.
  - `det` = `fall` (EDGE_MODE 0), `rise` (EDGE_MODE 1), or `fall | rise` (EDGE_MODE 2).
- `out` is a flop: `out <= det`. It has no combinational path from `i_btn`.
- While reset is asserted:
  - All `sr` bits are forced to IDLE_LEVEL and `out` is forced to 0, asynchronously, with no dependence on the clock.
  - `i_btn` activity is ignored.
  - No pulse is produced for a level difference between IDLE_LEVEL and `i_btn` that exists at reset release, until that level has propagated through `sr`.
- Consequence of reset release with `i_btn` ≠ IDLE_LEVEL: a genuine transition is seen as that level shifts in.
  - Example: IDLE_LEVEL = 0, `i_btn` = 1, EDGE_MODE 1 → one rise pulse.
  - This is required behaviour.
- A level held for several cycles produces one pulse only, at its start (falling/rising) or at each end (both).
- Input pulses shorter than one clock period may be missed. No pulse-stretching.
- Back-to-back toggles one cycle apart produce one pulse per toggle. In EDGE_MODE 2, `out` can stay high on consecutive cycles.
- No debounce filtering; mechanical bounce yields multiple pulses.

## Timing
- Let E0 be the first rising clock edge that samples a new `i_btn` value into `sr[0]`.
- The edge is visible in `s_new`/`s_old` after edge E0+SYNC_STAGES-1.
- `out` rises at edge E0+SYNC_STAGES and falls at edge E0+SYNC_STAGES+1.
- With default SYNC_STAGES = 2, latency from sampling to `out` high is 2 clocks.
- Pulse width is always exactly 1 `sys_clk` period.
- Reset behaviour:
  - Assertion clears `out` immediately, mid-pulse included.
  - The first edge after reset release shifts normally.
  - Reset asserted mid-sequence discards any in-flight transition.
- Reset values: `out` = 0; every `sr` bit = IDLE_LEVEL.

## Test plan
- Reset, then steady input:
  - Stimulus: reset asserted 20 ns (10 ns clock), released with `i_btn` = 0, defaults.
  - Required: `out` = 0 throughout reset and for 10 idle cycles.
- Falling edge:
  - Stimulus: `i_btn` 0→1 at E0, held 5 cycles, then 1→0 at E5.
  - Required: no pulse on the rise; `out` = 1 exactly during the cycle after E7, 0 otherwise.
- Re-press then reset:
  - Stimulus: `i_btn` 1 one cycle after release; reset asserted 2 cycles later for 1 cycle; released with `i_btn` = 0, then `i_btn` = 1.
  - Required: `out` stays 0 throughout; no spurious pulse from reset release.
- Reset mid-pulse:
  - Stimulus: assert reset on the cycle `out` = 1.
  - Required: `out` drops to 0 asynchronously, before the next clock edge.
- EDGE_MODE = 2, SYNC_STAGES = 3:
  - Stimulus: `i_btn` toggles 0→1→0 with 4-cycle spacing.
  - Required: two 1-cycle pulses, each 3 clocks after its sampling edge.
- EDGE_MODE = 1, IDLE_LEVEL = 0:
  - Stimulus: reset released while `i_btn` = 1.
  - Required: exactly one 1-cycle rise pulse, SYNC_STAGES clocks after release; no further pulses while held.
